// File: rtl/fp_access_ctrl.sv
// Flip-and-Patch access controller between a host request port and a faulty RAM.
// Flip-marked words are stored half-swapped; patch-marked words live in a small spare table.
module fp_access_ctrl #(
  parameter int N_WORDS = 1 << 20,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = $clog2(N_WORDS),
  parameter int N_PATCH = 16,
  localparam int HALF   = DATA_W / 2,
  localparam int PU_W   = $clog2(N_PATCH + 1),
  localparam int IDX_W  = (N_PATCH > 1) ? $clog2(N_PATCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              flip_bit,
  input  logic              patch_bit,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PU_W-1:0]   patch_used,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, LOOKUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                flip_q, patch_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;
  logic [PU_W-1:0]     patch_used_q;
  logic                valid_q [N_PATCH];
  logic [ADDR_W-1:0]   tag_q   [N_PATCH];
  logic [DATA_W-1:0]   data_q  [N_PATCH];

  logic                hit, free_found;
  logic [IDX_W-1:0]    hit_idx, free_idx;
  logic [DATA_W-1:0]   acc_rdata;
  logic                acc_err, tbl_wr, tbl_alloc;
  logic [IDX_W-1:0]    tbl_idx;

  // Handshakes: a transfer happens on a clock edge where valid and ready are both
  // high; once raised, resp_valid and its payload stay fixed until resp_ready.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign map_addr   = addr_q;
  assign patch_used = patch_used_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Spare table search: first matching valid entry, and lowest-index free entry.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < N_PATCH; i++) begin
      if (!hit && valid_q[i] && tag_q[i] == addr_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    acc_rdata = '0;
    acc_err   = 1'b0;
    tbl_wr    = 1'b0;
    tbl_alloc = 1'b0;
    tbl_idx   = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_addr = addr_q;
      if (patch_q) begin
        if (we_q) begin
          if (hit) begin
            tbl_wr  = 1'b1;
            tbl_idx = hit_idx;
          end else if (free_found) begin
            tbl_wr    = 1'b1;
            tbl_alloc = 1'b1;
            tbl_idx   = free_idx;
          end else begin
            acc_err = 1'b1;
          end
        end else if (hit) begin
          acc_rdata = data_q[hit_idx];
        end
      end else if (flip_q) begin
        mem_we    = we_q;
        mem_wdata = {wdata_q[HALF-1:0], wdata_q[DATA_W-1:HALF]};
        if (!we_q) acc_rdata = {mem_rdata[HALF-1:0], mem_rdata[DATA_W-1:HALF]};
      end else begin
        mem_we    = we_q;
        mem_wdata = wdata_q;
        if (!we_q) acc_rdata = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      flip_q       <= 1'b0;
      patch_q      <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      patch_used_q <= '0;
      for (int i = 0; i < N_PATCH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == LOOKUP) begin
        flip_q  <= flip_bit;
        patch_q <= patch_bit;
      end
      if (state_q == ACCESS) begin
        resp_rdata_q <= acc_rdata;
        resp_err_q   <= acc_err;
        if (tbl_wr) begin
          valid_q[tbl_idx] <= 1'b1;
          tag_q[tbl_idx]   <= addr_q;
          data_q[tbl_idx]  <= wdata_q;
        end
        if (tbl_alloc && patch_used_q != PU_W'(N_PATCH))
          patch_used_q <= patch_used_q + PU_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_access_ctrl.sv
// Self-checking bench for fp_access_ctrl: vector table, scoreboard queue, and
// hand-written backpressure and mid-transaction reset sequences.
module tb_fp_access_ctrl;
  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int NP  = 4;
  localparam int PUW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] map_addr;
  logic          flip_bit, patch_bit;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [PUW-1:0] patch_used;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  fp_access_ctrl #(.N_WORDS(256), .DATA_W(DW), .N_PATCH(NP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .map_addr(map_addr), .flip_bit(flip_bit), .patch_bit(patch_bit),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .patch_used(patch_used), .dbg_state(dbg_state)
  );

  // RAM model with physical bit 0 of word 9 stuck at 1
  logic [DW-1:0] ram [256] = '{default: '0};
  logic          flip_map  [256];
  logic          patch_map [256];
  assign mem_rdata = ram[mem_addr] | ((mem_addr == 8'd9) ? 16'h0001 : 16'h0000);
  assign flip_bit  = flip_map[map_addr];
  assign patch_bit = patch_map[map_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_mwe;
    logic [DW-1:0] exp_mwd;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    logic [PUW-1:0] exp_used;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic mwe, input logic [DW-1:0] mwd, input logic [DW-1:0] rd,
                         input logic err, input logic [PUW-1:0] used);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.exp_mwe = mwe; v.exp_mwd = mwd;
    v.exp_rd = rd; v.exp_err = err; v.exp_used = used;
    vecs.push_back(v);
  endtask

  // Called and returns at a negedge with resp_ready=1.
  task automatic do_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic exp_mwe, input logic [DW-1:0] exp_mwd,
                        input logic [DW-1:0] exp_rd, input logic exp_err);
    int lat;
    bit got;
    logic [DW:0] e;
    exp_q.push_back({exp_err, exp_rd});
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (lat < 10 && !got) begin
      @(negedge clk); lat++;
      if (dbg_state == 2'd2) begin
        chk("mem_we", mem_we, exp_mwe);
        chk("mem_addr", mem_addr, a);
        if (exp_mwe) chk("mem_wdata", mem_wdata, exp_mwd);
      end
      if (resp_valid) got = 1'b1;
    end
    chk("latency", got ? lat : 99, 3);
    e = exp_q.pop_front();
    if (got) begin
      chk("resp_rdata", resp_rdata, e[DW-1:0]);
      chk("resp_err", resp_err, e[DW]);
    end
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] swap(input logic [DW-1:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    for (int i = 0; i < 256; i++) begin
      flip_map[i]  = 1'b0;
      patch_map[i] = 1'b0;
    end
    flip_map[9] = 1'b1;
    patch_map[100] = 1'b1; patch_map[101] = 1'b1;
    flip_map[10] = 1'b1; patch_map[10] = 1'b1;
    for (int i = 200; i < 204; i++) patch_map[i] = 1'b1;
    for (int i = 20; i <= 60; i++) flip_map[i] = 1'($urandom_range(0, 1));

    repeat (3) @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_rdata", resp_rdata, 0);
    chk("rst resp_err", resp_err, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst map_addr", map_addr, 0);
    chk("rst patch_used", patch_used, 0);
    reset = 1'b0;
    @(negedge clk);

    //      we    addr    wdata     mwe   mem_wdata  rdata     err   used
    add_vec(1'b1, 8'd5,   16'h1234, 1'b1, 16'h1234, 16'h0000, 1'b0, 3'd0);
    add_vec(1'b0, 8'd5,   16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0, 3'd0);
    add_vec(1'b1, 8'd9,   16'hAB12, 1'b1, 16'h12AB, 16'h0000, 1'b0, 3'd0);
    add_vec(1'b0, 8'd9,   16'h0000, 1'b0, 16'h0000, 16'hAB12, 1'b0, 3'd0);
    add_vec(1'b1, 8'd9,   16'hAA12, 1'b1, 16'h12AA, 16'h0000, 1'b0, 3'd0);
    add_vec(1'b0, 8'd9,   16'h0000, 1'b0, 16'h0000, 16'hAB12, 1'b0, 3'd0);
    add_vec(1'b1, 8'd100, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd1);
    add_vec(1'b0, 8'd100, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 3'd1);
    add_vec(1'b0, 8'd101, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd1);
    add_vec(1'b1, 8'd10,  16'h5678, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd2);
    add_vec(1'b0, 8'd10,  16'h0000, 1'b0, 16'h0000, 16'h5678, 1'b0, 3'd2);
    add_vec(1'b1, 8'd200, 16'h1111, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd3);
    add_vec(1'b1, 8'd201, 16'h2222, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd4);
    add_vec(1'b1, 8'd202, 16'h3333, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd4);
    add_vec(1'b1, 8'd100, 16'hCAFE, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd4);
    add_vec(1'b0, 8'd100, 16'h0000, 1'b0, 16'h0000, 16'hCAFE, 1'b0, 3'd4);
    add_vec(1'b0, 8'd202, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd4);
    add_vec(1'b0, 8'd201, 16'h0000, 1'b0, 16'h0000, 16'h2222, 1'b0, 3'd4);

    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_mwe,
             vecs[i].exp_mwd, vecs[i].exp_rd, vecs[i].exp_err);
      chk($sformatf("patch_used v%0d", i), patch_used, vecs[i].exp_used);
    end

    // Random clean/flip words away from the faulty location
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(20, 60));
      rd = 16'($urandom);
      do_txn(1'b1, ra, rd, 1'b1, flip_map[ra] ? swap(rd) : rd, 16'h0000, 1'b0);
      do_txn(1'b0, ra, 16'h0000, 1'b0, 16'h0000, rd, 1'b0);
    end

    // Backpressure: response holds while resp_ready is low; new requests are ignored
    resp_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h1234});
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("bp resp_valid rise", resp_valid, 1);
    begin
      logic [DW:0] e;
      e = exp_q.pop_front();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd9; req_wdata = 16'hFFFF;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk("bp resp_valid", resp_valid, 1);
        chk("bp resp_rdata", resp_rdata, e[DW-1:0]);
        chk("bp resp_err", resp_err, e[DW]);
        chk("bp req_ready", req_ready, 0);
      end
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp release state", dbg_state, 0);
    do_txn(1'b0, 8'd9, 16'h0000, 1'b0, 16'h0000, 16'hAB12, 1'b0);

    // Reset during ACCESS of a patched write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd100; req_wdata = 16'h9999;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst mid state", dbg_state, 2);
    reset = 1'b1;
    #1;
    chk("rst mid patch_used", patch_used, 0);
    chk("rst mid mem_we", mem_we, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst mid no resp", resp_valid, 0);
    end
    do_txn(1'b0, 8'd100, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    do_txn(1'b0, 8'd201, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("post rst patch_used", patch_used, 0);
    do_txn(1'b0, 8'd5, 16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0);

    chk("scoreboard empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_access_ctrl.md
# fp_access_ctrl

Run-time Flip-and-Patch access controller; it consumes the per-word `flipping_bit`/`patching_bit` maps produced by the fault classification sweep. It sits between a host request port and the faulty RAM.
- Flip-marked words are stored half-swapped, so high-order stuck faults land in low-order bit positions.
- Patch-marked words are redirected to a small internal spare table.
- Clean words pass through unchanged.

## Interface
Parameters:
- `N_WORDS`, 1<<20, words in the RAM
- `DATA_W`, 16, word width; must be even; `HALF` = `DATA_W`/2
- `ADDR_W`, $clog2(N_WORDS), address width
- `N_PATCH`, 16, spare table entries

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  host request valid
- `req_ready`  out  1  controller can accept a request
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  word address
- `req_wdata`  in  DATA_W  write data
- `resp_valid`  out  1  response valid
- `resp_ready`  in  1  host accepts response
- `resp_rdata`  out  DATA_W  read data, restored to logical order; 0 for writes
- `resp_err`  out  1  write dropped because the patch table is full
- `map_addr`  out  ADDR_W  index into the flip/patch maps
- `flip_bit`  in  1  `flipping_bit[map_addr]`, combinational
- `patch_bit`  in  1  `patching_bit[map_addr]`, combinational
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, combinational from `mem_addr`
- `patch_used`  out  $clog2(N_PATCH+1)  allocated spare entries

## Operation
FSM states: IDLE, LOOKUP, ACCESS, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`: register `we`/`addr`/`wdata`, then go to LOOKUP.
- **LOOKUP:**
  - `map_addr` = registered addr; `flip_bit`/`patch_bit` are sampled at the clock edge.
  - Next state is ACCESS.
  - `map_addr` holds the last registered addr in all other states.
- **ACCESS (patch_bit=1, patch wins if both flags are set):**
  - Search the spare table for a valid entry with tag == addr.
  - Write, hit: overwrite the entry's data.
  - Write, miss, table not full: allocate the lowest-index free entry {valid, tag, data}; `patch_used`+1.
  - Write, miss, table full: drop the write; `resp_err`=1.
  - Read, hit: return the entry's data.
  - Read, miss: return 0, `resp_err`=0.
  - No RAM write (`mem_we`=0).
- **ACCESS (flip_bit=1 only):**
  - Write: `mem_we`=1, `mem_wdata` = {wdata[HALF-1:0], wdata[DATA_W-1:HALF]}.
  - Read: rdata = {mem_rdata[HALF-1:0], mem_rdata[DATA_W-1:HALF]}.
- **ACCESS (clean word):**
  - Write: `mem_wdata` = wdata.
  - Read: rdata = mem_rdata.
- In ACCESS, `mem_addr` = registered addr. Outside ACCESS, `mem_we`=0 and `mem_addr`=0.
- After ACCESS the FSM goes to RESP.
- **RESP:** `resp_valid`=1 with `resp_rdata`/`resp_err` held stable; go to IDLE on `resp_ready`.
- Spare entries are never freed except by reset.

## Timing
- Request accepted at edge E0 (`req_valid`&`req_ready`).
- LOOKUP occupies the cycle after E0.
- ACCESS occupies the next cycle; the RAM write commits at the end of ACCESS.
- `resp_valid` rises in the third cycle after E0; minimum latency is 3 cycles.
- Throughput is 1 request per 4 cycles when `resp_ready` is held at 1.
- `req_ready` is low from E0 until RESP completes. Requests presented meanwhile are ignored, not queued.
- A response stalled by `resp_ready`=0 holds indefinitely with no state change.
- Reset values:
  - state IDLE;
  - `req_ready`=1;
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `map_addr`=0;
  - `patch_used`=0;
  - all spare entries invalid.
- Reset asserted mid-transaction aborts it at once: no RAM write, no response, table cleared.
- `patch_used` saturates at N_PATCH; allocation never exceeds N_PATCH.

## Test plan
- Clean word: map flags 0,0 at addr 5; write 0x1234, read addr 5 -> `mem_wdata`=0x1234 in ACCESS; read `resp_rdata`=0x1234 with `resp_valid` 3 cycles after acceptance.
- Flip word: addr 9 flip=1; write 0xAB12 -> `mem_wdata`=0x12AB. Force a stuck-at-1 on physical bit 0 (logical bit 8); read -> `resp_rdata`=0xAB12 with the error confined to bit 8 (0xAB12 | 0x0100 = 0xAB12).
- Patch word: addr 100 patch=1; write 0xBEEF -> `mem_we` stays 0, `patch_used`=1; read -> 0xBEEF; read of patched but unwritten addr 101 -> 0x0000, `resp_err`=0.
- Table full: N_PATCH=4; write 5 distinct patched addrs -> 5th response `resp_err`=1, `patch_used`=4; rewrite of the 1st addr still succeeds with `resp_err`=0.
- Backpressure and reset: hold `resp_ready`=0 for 10 cycles -> response stable, `req_ready`=0; assert reset during ACCESS of a patched write -> no response, `patch_used`=0, next read returns 0.
